// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for an N-bit radix-2 Booth multiplier datapath.
// Issues one TEST/[ADD|SUB]/SHIFT iteration per multiplier bit and counts add/sub operations.
module booth_seq_ctrl #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    next_op,
   output logic          cla,
   output logic          ldy,
   output logic          ldx,
   output logic          ldx_1,
   output logic          lda,
   output logic          sel,
   output logic          is_add,
   output logic          is_sub,
   output logic          sha,
   output logic          shx,
   output logic          shx_1,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] op_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      SHIFT = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] opc_q, opc_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opc_q   <= opc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opc_d   = opc_q;
      case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD: begin
            cnt_d   = CW'(N);
            opc_d   = '0;
            state_d = TEST;
         end
         TEST: begin
            case (next_op)
               2'b10:   state_d = SUB;
               2'b01:   state_d = ADD;
               default: state_d = SHIFT;
            endcase
         end
         ADD, SUB: begin
            opc_d   = opc_q + CW'(1);
            state_d = SHIFT;
         end
         SHIFT: begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? DONE : TEST;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore decode only; the unused encoding falls to the all-zero default.
   always_comb begin
      cla    = 1'b0;
      ldy    = 1'b0;
      ldx    = 1'b0;
      ldx_1  = 1'b0;
      lda    = 1'b0;
      sel    = 1'b0;
      is_add = 1'b0;
      is_sub = 1'b0;
      sha    = 1'b0;
      shx    = 1'b0;
      shx_1  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state_q)
         LOAD: begin
            cla   = 1'b1;
            ldy   = 1'b1;
            ldx   = 1'b1;
            ldx_1 = 1'b1;
            busy  = 1'b1;
         end
         TEST: busy = 1'b1;
         ADD: begin
            lda    = 1'b1;
            sel    = 1'b1;
            is_add = 1'b1;
            busy   = 1'b1;
         end
         SUB: begin
            lda    = 1'b1;
            sel    = 1'b1;
            is_sub = 1'b1;
            busy   = 1'b1;
         end
         SHIFT: begin
            sha   = 1'b1;
            shx   = 1'b1;
            shx_1 = 1'b1;
            busy  = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign op_count = opc_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural Booth datapath closing the next_op loop.
module tb_booth_seq_ctrl;
   localparam int N  = 4;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    next_op;
   logic          cla, ldy, ldx, ldx_1, lda, sel, is_add, is_sub;
   logic          sha, shx, shx_1, busy, done;
   logic [CW-1:0] op_count;

   int n_assert = 0;
   int n_fail   = 0;

   booth_seq_ctrl #(.N(N), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .next_op(next_op),
      .cla(cla), .ldy(ldy), .ldx(ldx), .ldx_1(ldx_1), .lda(lda), .sel(sel),
      .is_add(is_add), .is_sub(is_sub), .sha(sha), .shx(shx), .shx_1(shx_1),
      .busy(busy), .done(done), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: A, X, x_1, Y driven by the controller's strobes.
   logic [N-1:0] a_q = '0, x_q = '0, y_q = '0;
   logic         x1_q = 1'b0;
   logic [N-1:0] x_in = '0, y_in = '0;

   always @(posedge clk) begin
      if (cla)   a_q  <= '0;
      if (ldy)   y_q  <= y_in;
      if (ldx)   x_q  <= x_in;
      if (ldx_1) x1_q <= 1'b0;
      if (lda && sel) a_q <= is_add ? a_q + y_q : (is_sub ? a_q - y_q : a_q);
      if (sha)   a_q  <= {a_q[N-1], a_q[N-1:1]};
      if (shx)   x_q  <= {a_q[0], x_q[N-1:1]};
      if (shx_1) x1_q <= x_q[0];
   end
   assign next_op = {x_q[0], x1_q};

   wire [12+CW:0] all_outs = {cla, ldy, ldx, ldx_1, lda, sel, is_add, is_sub,
                              sha, shx, shx_1, busy, done, op_count};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check("add_sub_excl", 32'(is_add & is_sub), 32'd0);
         check("lda_sha_excl", 32'(lda & sha), 32'd0);
         if (done) begin
            check("busy_in_done", 32'(busy), 32'd0);
            check("done_width", 32'(prev_done), 32'd0);
         end
      end
      prev_done = done;
   end

   task automatic run_mul(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input int exp_lat, input int exp_ops, input logic [2*N-1:0] exp_prod,
                          input bit pulse_test, input bit pulse_done);
      int  lat = 0, shifts = 0;
      bit  pulsed = 0, clr = 0;
      x_in = x;
      y_in = y;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            check({tag, "_load"}, 32'({cla, ldy, ldx, ldx_1, busy}), 32'h1f);
         end
         if (clr) begin
            start = 1'b0;
            clr   = 0;
         end
         if (pulse_test && !pulsed && i > 1 && busy && !lda && !sha) begin
            start  = 1'b1;
            pulsed = 1;
            clr    = 1;
         end
         if (sha) shifts++;
         if (done) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_shifts"}, 32'(shifts), 32'(N));
      check({tag, "_opcount"}, 32'(op_count), 32'(exp_ops));
      check({tag, "_product"}, 32'({a_q, x_q}), 32'(exp_prod));
      if (pulse_done) begin
         bit woke = 0;
         start = 1'b1;
         @(negedge clk) start = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (busy || cla) woke = 1;
            @(negedge clk);
         end
         check({tag, "_done_start_ignored"}, 32'(woke), 32'd0);
      end
   endtask

   initial begin
      int sh_cnt, ndone, nloads, last_done;
      bit bad;
      reset = 1'b0;
      start = 1'b0;
      #1;
      check("reset_outputs", 32'(all_outs), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_outputs", 32'(all_outs), 32'd0);

      run_mul("x0", 4'b0000, 4'd5, 10, 0, 8'h00, 0, 0);
      run_mul("x5", 4'b0101, 4'd3, 14, 4, 8'h0F, 0, 0);
      repeat (3) @(negedge clk);
      check("opcount_hold", 32'(op_count), 32'd4);
      run_mul("xm1", 4'b1111, 4'd3, 11, 1, 8'hFD, 0, 0);
      run_mul("pulse", 4'b0101, 4'd3, 14, 4, 8'h0F, 1, 1);

      // Asynchronous reset during the third SHIFT.
      x_in = 4'b0101;
      y_in = 4'd3;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      sh_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (sha) sh_cnt++;
         if (sh_cnt == 3) break;
         @(negedge clk);
      end
      check("reached_3rd_shift", 32'(sh_cnt), 32'd3);
      reset = 1'b0;
      #1;
      check("async_abort_outputs", 32'(all_outs), 32'd0);
      @(negedge clk) reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) bad = 1;
      end
      check("no_done_after_abort", 32'(bad), 32'd0);
      run_mul("after_rst", 4'b0101, 4'd3, 14, 4, 8'h0F, 0, 0);

      // start held high: DONE, one IDLE, then LOAD.
      x_in = 4'b0000;
      y_in = 4'd5;
      ndone = 0;
      nloads = 0;
      last_done = 0;
      @(negedge clk) start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            last_done = i;
         end
         if (cla) begin
            nloads++;
            if (last_done > 0) check("b2b_gap", 32'(i - last_done), 32'd2);
         end
      end
      start = 1'b0;
      check("b2b_dones", 32'(ndone), 32'd2);
      check("b2b_loads", 32'(nloads), 32'd3);
      bad = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy && !done && !cla) begin
            bad = 0;
            break;
         end
      end
      check("b2b_settle", 32'(bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
